dt1_store_buffer: RTL and testbench
===================================

DT1_STORE_BUFFER -- requirements
Module: dt1_store_buffer

Interface
REQ-001 Parameter DEPTH, default 2, number of store entries; SHALL be a power of two, minimum 2.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 StoreValidM  input  1  memory-stage store request.
REQ-005 StoreSizeM  input  2  store size: 00 sw, 01 sb, 10 sh, 11 reserved.
REQ-006 ALUResultM  input  32  store byte address.
REQ-007 WriteDataM  input  32  unaligned store data from rs2.
REQ-008 StoreReadyM  output  1  buffer can accept a store this cycle.
REQ-009 LoadValidM, LoadAddrM  input  1, 32  memory-stage load and its byte address.
REQ-010 LoadHitM  output  1  load word matches a pending store; the pipeline stalls.
REQ-011 mem_req, mem_addr, mem_wdata, mem_be  output  1, 32, 32, 4  data-memory write request: word address, lane-replicated data, byte enables.
REQ-012 mem_ack  input  1  memory accepts the head write this cycle.
REQ-013 DrainedM  output  1  buffer empty; used for fence.
REQ-014 StoreMisalignM  output  1  registered one-cycle misalignment pulse.

Function
REQ-015 A store SHALL be accepted when StoreValidM && StoreReadyM && StoreSizeM!=11; StoreReadyM SHALL equal (count<DEPTH).
REQ-016 Alignment rules:
- sb: mem_be = 4'b0001<<addr[1:0]; data = {4{WriteDataM[7:0]}}.
- sh: mem_be = addr[1] ? 1100 : 0011; data = {2{WriteDataM[15:0]}}.
- sw: mem_be = 1111; data = WriteDataM.
- Stored address = {addr[31:2],2'b00}.
REQ-017 Aligned fields SHALL be computed at enqueue and stored per entry; head outputs SHALL be driven from registers only.
REQ-018 mem_req SHALL equal (count!=0); mem_addr, mem_wdata and mem_be SHALL hold stable while mem_req && !mem_ack.
REQ-019 The head SHALL pop on mem_req && mem_ack; stores SHALL drain in FIFO order.
REQ-020 Latency: a store accepted at edge N SHALL raise mem_req no earlier than the cycle after edge N (no bypass).
REQ-021 Simultaneous accept and pop SHALL leave count unchanged. When full, accept SHALL be refused even if mem_ack is high that cycle.
REQ-022 Pointers SHALL wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits wide.
REQ-023 LoadHitM SHALL be combinational: LoadValidM && any valid entry address == {LoadAddrM[31:2],2'b00}; an entry popping this cycle still counts as a hit.
REQ-024 StoreSizeM=11 SHALL be ignored: no enqueue, no misalignment pulse.
REQ-025 DrainedM SHALL equal (count==0).

Reset
REQ-026 On rst, all entries SHALL be invalidated and pointers and count zeroed. On the next cycle: mem_req=0, StoreReadyM=1, DrainedM=1, StoreMisalignM=0. Data registers need no reset.
REQ-027 Reset during a pending write SHALL abandon it; mem_ack received while rst is high SHALL be ignored.

Configuration
REQ-028 Macro DT1_STORE_MISALIGN_TRAP_EN.
- Defined: sh with addr[0]=1, or sw with addr[1:0]!=0, SHALL NOT enqueue and SHALL pulse StoreMisalignM for one cycle after the edge.
- Undefined: offending low address bits SHALL be ignored (sh uses addr[1]; sw uses word address), the store SHALL enqueue, and StoreMisalignM SHALL be tied 0.

Structure
REQ-029 Package dt1_pkg SHALL hold the store-size encodings (shared with the load-size decode) and the constant DT1_STORE_DEPTH_DEFAULT.
REQ-030 Combinational sub-module dt1_store_align SHALL compute mem_be, replicated data, word address and the misalign flag; dt1_store_buffer SHALL instantiate it once.

Verification
REQ-031 sb to addr 0x1003 with data 0xAABBCCDD -> mem_addr 0x1000, mem_be 1000, mem_wdata 0xDDDDDDDD.
REQ-032 sh to 0x2002 with data 0x12345678 -> mem_be 1100, mem_wdata 0x56785678. With the macro, sh to 0x2001 -> StoreMisalignM pulse and no mem_req.
REQ-033 Three back-to-back sw with DEPTH=2 and mem_ack=0 -> StoreReadyM=0 on the third; raising mem_ack -> writes in order, third accepted afterwards.
REQ-034 Full buffer, mem_ack=1 and StoreValidM=1 in the same cycle -> pop occurs, push refused, count becomes 1.
REQ-035 Pending sw to 0x3000; lw from 0x3002 -> LoadHitM=1; LoadHitM clears the cycle after mem_ack.
REQ-036 rst while 2 entries pending and mem_ack=1 -> mem_req=0 and DrainedM=1 next cycle; no further writes issued.

Source files
------------

// File: rtl/dt1_pkg.sv
// Shared definitions for the dt1 data-side memory path.
// Holds the store/load size encodings, the aligned store entry record and the
// default store-buffer depth.
package dt1_pkg;

  // Size encoding shared by the store path and the load-size decode.
  typedef enum logic [1:0] {
    SizeWord = 2'b00,
    SizeByte = 2'b01,
    SizeHalf = 2'b10,
    SizeRsvd = 2'b11
  } store_size_e;

  localparam int unsigned DT1_STORE_DEPTH_DEFAULT = 2;

  // One store after alignment: word address, lane-replicated data, byte enables.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } store_entry_t;

endpackage

// File: rtl/dt1_store_align.sv
// Combinational store alignment.
// Turns a byte address, store size and raw rs2 data into the word address,
// lane-replicated write data and byte enables, and flags a misaligned access.
// Ports:
//   size      in   store size (dt1_pkg::store_size_e)
//   addr      in   store byte address
//   wdata     in   unaligned store data
//   entry     out  aligned word address / data / byte enables
//   misalign  out  sh with addr[0] set, or sw with addr[1:0] non-zero
module dt1_store_align
  import dt1_pkg::*;
(
  input  store_size_e  size,
  input  logic [31:0]  addr,
  input  logic [31:0]  wdata,
  output store_entry_t entry,
  output logic         misalign
);

  always_comb begin
    entry.addr = {addr[31:2], 2'b00};
    entry.data = '0;
    entry.be   = '0;
    misalign   = 1'b0;
    case (size)
      SizeByte: begin
        entry.be   = 4'b0001 << addr[1:0];
        entry.data = {4{wdata[7:0]}};
      end
      SizeHalf: begin
        // Only addr[1] picks the half; addr[0] is reported, not used.
        entry.be   = addr[1] ? 4'b1100 : 4'b0011;
        entry.data = {2{wdata[15:0]}};
        misalign   = addr[0];
      end
      SizeWord: begin
        entry.be   = 4'b1111;
        entry.data = wdata;
        misalign   = (addr[1:0] != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dt1_store_buffer.sv
// FIFO store buffer between the memory stage and the data memory.
// Stores are aligned at enqueue and drained in order through a single write
// port; loads to a word with a pending store raise LoadHitM so the pipeline
// stalls. Optional macro DT1_STORE_MISALIGN_TRAP_EN rejects misaligned sh/sw
// and pulses StoreMisalignM; without it low address bits are ignored.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   StoreValidM/SizeM          store request and size
//   ALUResultM, WriteDataM     store byte address and rs2 data
//   StoreReadyM                buffer has space
//   LoadValidM, LoadAddrM      load probe; LoadHitM when it matches an entry
//   mem_req/addr/wdata/be      head write request; mem_ack pops the head
//   DrainedM                   buffer empty
//   StoreMisalignM             registered one-cycle misalignment pulse
module dt1_store_buffer
  import dt1_pkg::*;
#(
  parameter int unsigned DEPTH = DT1_STORE_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StoreValidM,
  input  logic [1:0]  StoreSizeM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StoreReadyM,
  input  logic        LoadValidM,
  input  logic [31:0] LoadAddrM,
  output logic        LoadHitM,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        DrainedM,
  output logic        StoreMisalignM
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  store_entry_t        aligned;
  logic                misalign;
  logic                size_ok;
  logic                trap;
  logic                push;
  logic                pop;

  logic [PtrW-1:0]     head_q, head_d;
  logic [PtrW-1:0]     tail_q, tail_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  store_entry_t        entry_q [DEPTH];

  logic [31:0]         load_word;
  logic                load_match;

  dt1_store_align u_align (
    .size     (store_size_e'(StoreSizeM)),
    .addr     (ALUResultM),
    .wdata    (WriteDataM),
    .entry    (aligned),
    .misalign (misalign)
  );

  assign size_ok = (StoreSizeM != SizeRsvd);

`ifdef DT1_STORE_MISALIGN_TRAP_EN
  logic misalign_q;

  assign trap = size_ok && misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= StoreValidM && trap;
    end
  end

  assign StoreMisalignM = misalign_q;
`else
  logic unused_misalign;

  assign unused_misalign = misalign;
  assign trap            = 1'b0;
  assign StoreMisalignM  = 1'b0;
`endif

  assign StoreReadyM = (count_q < CntW'(DEPTH));
  assign mem_req     = (count_q != '0);
  assign DrainedM    = (count_q == '0);
  assign push        = StoreValidM && StoreReadyM && size_ok && !trap;
  assign pop         = mem_req && mem_ack;

  // Head drives the write port straight from the entry registers.
  assign mem_addr  = entry_q[head_q].addr;
  assign mem_wdata = entry_q[head_q].data;
  assign mem_be    = entry_q[head_q].be;

  // push and pop never target the same slot: that needs count 0 or DEPTH,
  // where one of them is blocked.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PtrW'(1);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload needs no reset; valid_q qualifies every use.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_q[tail_q] <= aligned;
    end
  end

  // An entry popping this cycle is still valid here, so it still hits.
  assign load_word = LoadAddrM & 32'hFFFF_FFFC;

  always_comb begin
    load_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (entry_q[i].addr == load_word)) begin
        load_match = 1'b1;
      end
    end
  end

  assign LoadHitM = LoadValidM && load_match;

endmodule

// File: tb/tb_dt1_store_buffer.sv
// Directed self-checking bench for dt1_store_buffer (DEPTH = 2).
module tb_dt1_store_buffer;

  logic        clk;
  logic        rst;
  logic        StoreValidM;
  logic [1:0]  StoreSizeM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        StoreReadyM;
  logic        LoadValidM;
  logic [31:0] LoadAddrM;
  logic        LoadHitM;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        DrainedM;
  logic        StoreMisalignM;

  int checks;
  int failures;

  dt1_store_buffer #(.DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .StoreValidM    (StoreValidM),
    .StoreSizeM     (StoreSizeM),
    .ALUResultM     (ALUResultM),
    .WriteDataM     (WriteDataM),
    .StoreReadyM    (StoreReadyM),
    .LoadValidM     (LoadValidM),
    .LoadAddrM      (LoadAddrM),
    .LoadHitM       (LoadHitM),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_be         (mem_be),
    .mem_ack        (mem_ack),
    .DrainedM       (DrainedM),
    .StoreMisalignM (StoreMisalignM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past a rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req);
    end
    checks++;
    if (StoreReadyM !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b exp=1", StoreReadyM);
    end
    checks++;
    if (DrainedM !== 1'b1) begin
      failures++; $display("FAIL reset_drained got=%b exp=1", DrainedM);
    end
    checks++;
    if (StoreMisalignM !== 1'b0) begin
      failures++; $display("FAIL reset_misalign got=%b exp=0", StoreMisalignM);
    end
  endtask

  task automatic test_sb();
    StoreValidM = 1'b1; StoreSizeM = 2'b01;
    ALUResultM = 32'h0000_1003; WriteDataM = 32'hAABB_CCDD;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++; $display("FAIL sb_no_bypass got=%b exp=0", mem_req);
    end
    tick();
    StoreValidM = 1'b0;
    checks++;
    if ({mem_req, mem_addr, mem_be, mem_wdata} !== {1'b1, 32'h0000_1000, 4'b1000, 32'hDDDD_DDDD})
    begin
      failures++;
      $display("FAIL sb_fields got req=%b addr=%h be=%b data=%h exp 1 00001000 1000 dddddddd",
               mem_req, mem_addr, mem_be, mem_wdata);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({mem_req, DrainedM} !== 2'b01) begin
      failures++; $display("FAIL sb_drain got req=%b drained=%b exp 0 1", mem_req, DrainedM);
    end
  endtask

  task automatic test_sh();
    StoreValidM = 1'b1; StoreSizeM = 2'b10;
    ALUResultM = 32'h0000_2002; WriteDataM = 32'h1234_5678;
    tick();
    StoreValidM = 1'b0;
    checks++;
    if ({mem_addr, mem_be, mem_wdata} !== {32'h0000_2000, 4'b1100, 32'h5678_5678}) begin
      failures++;
      $display("FAIL sh_fields got addr=%h be=%b data=%h exp 00002000 1100 56785678",
               mem_addr, mem_be, mem_wdata);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic test_sh_misalign();
    StoreValidM = 1'b1; StoreSizeM = 2'b10;
    ALUResultM = 32'h0000_2001; WriteDataM = 32'h0000_BEEF;
    tick();
    StoreValidM = 1'b0;
`ifdef DT1_STORE_MISALIGN_TRAP_EN
    checks++;
    if ({StoreMisalignM, mem_req} !== 2'b10) begin
      failures++;
      $display("FAIL sh_trap got pulse=%b req=%b exp 1 0", StoreMisalignM, mem_req);
    end
    tick();
    checks++;
    if ({StoreMisalignM, mem_req} !== 2'b00) begin
      failures++;
      $display("FAIL sh_trap_clear got pulse=%b req=%b exp 0 0", StoreMisalignM, mem_req);
    end
`else
    checks++;
    if ({StoreMisalignM, mem_req, mem_addr, mem_be, mem_wdata} !==
        {1'b0, 1'b1, 32'h0000_2000, 4'b0011, 32'hBEEF_BEEF}) begin
      failures++;
      $display("FAIL sh_odd got pulse=%b req=%b addr=%h be=%b data=%h exp 0 1 00002000 0011 beefbeef",
               StoreMisalignM, mem_req, mem_addr, mem_be, mem_wdata);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
`endif
  endtask

  task automatic test_reserved();
    StoreValidM = 1'b1; StoreSizeM = 2'b11;
    ALUResultM = 32'h0000_4001; WriteDataM = 32'h1111_1111;
    tick();
    StoreValidM = 1'b0;
    checks++;
    if ({mem_req, DrainedM, StoreMisalignM} !== 3'b010) begin
      failures++;
      $display("FAIL reserved got req=%b drained=%b pulse=%b exp 0 1 0",
               mem_req, DrainedM, StoreMisalignM);
    end
  endtask

  task automatic test_back_to_back();
    StoreValidM = 1'b1; StoreSizeM = 2'b00;
    ALUResultM = 32'h0000_0100; WriteDataM = 32'hA1A1_A1A1;
    tick();
    ALUResultM = 32'h0000_0104; WriteDataM = 32'hB2B2_B2B2;
    tick();
    ALUResultM = 32'h0000_0108; WriteDataM = 32'hC3C3_C3C3;
    #1;
    checks++;
    if (StoreReadyM !== 1'b0) begin
      failures++; $display("FAIL b2b_full_ready got=%b exp=0", StoreReadyM);
    end
    tick();
    checks++;
    if ({StoreReadyM, mem_addr, mem_wdata} !== {1'b0, 32'h0000_0100, 32'hA1A1_A1A1}) begin
      failures++;
      $display("FAIL b2b_hold got ready=%b addr=%h data=%h exp 0 00000100 a1a1a1a1",
               StoreReadyM, mem_addr, mem_wdata);
    end
    // Full with ack and a store offered: pop only, count drops to 1.
    mem_ack = 1'b1;
    tick();
    checks++;
    if ({StoreReadyM, mem_req, mem_addr, mem_wdata} !==
        {1'b1, 1'b1, 32'h0000_0104, 32'hB2B2_B2B2}) begin
      failures++;
      $display("FAIL full_ack_pop got ready=%b req=%b addr=%h data=%h exp 1 1 00000104 b2b2b2b2",
               StoreReadyM, mem_req, mem_addr, mem_wdata);
    end
    // Push and pop together: count stays 1, third store now at head.
    tick();
    StoreValidM = 1'b0;
    checks++;
    if ({StoreReadyM, mem_req, mem_addr, mem_wdata, mem_be} !==
        {1'b1, 1'b1, 32'h0000_0108, 32'hC3C3_C3C3, 4'b1111}) begin
      failures++;
      $display("FAIL b2b_third got ready=%b req=%b addr=%h data=%h be=%b exp 1 1 00000108 c3c3c3c3 1111",
               StoreReadyM, mem_req, mem_addr, mem_wdata, mem_be);
    end
    tick();
    mem_ack = 1'b0;
    checks++;
    if (DrainedM !== 1'b1) begin
      failures++; $display("FAIL b2b_drained got=%b exp=1", DrainedM);
    end
  endtask

  task automatic test_load_hit();
    StoreValidM = 1'b1; StoreSizeM = 2'b00;
    ALUResultM = 32'h0000_3000; WriteDataM = 32'h5555_AAAA;
    tick();
    StoreValidM = 1'b0;
    LoadValidM = 1'b1; LoadAddrM = 32'h0000_3002;
    #1;
    checks++;
    if (LoadHitM !== 1'b1) begin
      failures++; $display("FAIL load_hit got=%b exp=1", LoadHitM);
    end
    LoadAddrM = 32'h0000_3004;
    #1;
    checks++;
    if (LoadHitM !== 1'b0) begin
      failures++; $display("FAIL load_other_word got=%b exp=0", LoadHitM);
    end
    LoadValidM = 1'b0; LoadAddrM = 32'h0000_3002;
    #1;
    checks++;
    if (LoadHitM !== 1'b0) begin
      failures++; $display("FAIL load_not_valid got=%b exp=0", LoadHitM);
    end
    LoadValidM = 1'b1; mem_ack = 1'b1;
    #1;
    checks++;
    if (LoadHitM !== 1'b1) begin
      failures++; $display("FAIL load_hit_popping got=%b exp=1", LoadHitM);
    end
    tick();
    mem_ack = 1'b0;
    checks++;
    if (LoadHitM !== 1'b0) begin
      failures++; $display("FAIL load_hit_after_ack got=%b exp=0", LoadHitM);
    end
    LoadValidM = 1'b0;
  endtask

  task automatic test_reset_pending();
    int writes;
    StoreValidM = 1'b1; StoreSizeM = 2'b00;
    ALUResultM = 32'h0000_5000; WriteDataM = 32'h1234_0000;
    tick();
    ALUResultM = 32'h0000_5004;
    tick();
    StoreValidM = 1'b0;
    rst = 1'b1; mem_ack = 1'b1;
    tick();
    rst = 1'b0; mem_ack = 1'b0;
    checks++;
    if ({mem_req, DrainedM, StoreReadyM} !== 3'b011) begin
      failures++;
      $display("FAIL rst_pending got req=%b drained=%b ready=%b exp 0 1 1",
               mem_req, DrainedM, StoreReadyM);
    end
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_req) writes++;
    end
    checks++;
    if (writes !== 0) begin
      failures++; $display("FAIL rst_no_writes got=%0d exp=0", writes);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; StoreValidM = 1'b0; StoreSizeM = 2'b00;
    ALUResultM = '0; WriteDataM = '0; LoadValidM = 1'b0; LoadAddrM = '0; mem_ack = 1'b0;
    #1;
    test_reset();
    test_sb();
    test_sh();
    test_sh_misalign();
    test_reserved();
    test_back_to_back();
    test_load_hit();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
